// File: rtl/w_arb_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter.
// Holds the arbiter state encoding and the burst counter width helper.
package w_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_MAX_BURST  = 4;

    function automatic int cnt_width(input int max_burst);
        return (max_burst > 1) ? $clog2(max_burst) : 1;
    endfunction

endpackage

// File: rtl/w_port_arbiter_if.sv
// Requester/FIFO-write-side bundle of the write-port arbiter.
// master = arbiter side, slave = requesters plus FIFO side.
interface w_port_arbiter_if
    import w_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic                          w_full;
    logic                          w_en;
    logic [DATA_WIDTH-1:0]         w_data;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            ack;
    logic                          busy;

    modport master (
        input  req, req_data, w_full,
        output w_en, w_data, gnt, ack, busy
    );

    modport slave (
        output req, req_data, w_full,
        input  w_en, w_data, gnt, ack, busy
    );
endinterface

// File: rtl/rr_pick.sv
// Round-robin pick: first requesting index strictly after last_sel, wrapping.
// Purely combinational; any_req flags that at least one request is present.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int SEL_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   last_sel,
    output logic [SEL_W-1:0]   sel,
    output logic               any_req
);

    always_comb begin
        int  idx;
        logic found;
        idx     = 0;
        found   = 1'b0;
        sel     = '0;
        any_req = |req;
        // Offset 1 first, so the previous winner has lowest priority.
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(last_sel) + i) % NUM_REQ;
            if (!found && req[idx]) begin
                sel   = SEL_W'(idx);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/w_port_arbiter.sv
// Shares one FIFO write port among NUM_REQ requesters with round-robin bursts.
// Grant one cycle after request; writes stall while w_full, burst ends on MAX_BURST or req drop.
module w_port_arbiter
    import w_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAX_BURST  = DEF_MAX_BURST
) (
    input  logic              w_clk,
    input  logic              wrst_n,
    w_port_arbiter_if.master  bus
);

    localparam int SEL_W = $clog2(NUM_REQ);
    localparam int CNT_W = cnt_width(MAX_BURST);

    state_t             state;
    logic [NUM_REQ-1:0] gnt;
    logic [SEL_W-1:0]   sel;
    logic [SEL_W-1:0]   last_sel;
    logic [SEL_W-1:0]   pick;
    logic               any_req;
    logic [CNT_W-1:0]   burst_cnt;
    logic               busy;
    logic               w_en;
    logic               last_beat;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .SEL_W   (SEL_W)
    ) u_rr_pick (
        .req      (bus.req),
        .last_sel (last_sel),
        .sel      (pick),
        .any_req  (any_req)
    );

    assign busy      = (state == BURST);
    // Reset gates the write so a mid-burst reset never leaks a word.
    assign w_en      = busy & bus.req[sel] & ~bus.w_full & wrst_n;
    assign last_beat = (burst_cnt == CNT_W'(MAX_BURST - 1));

    always_ff @(posedge w_clk) begin
        if (!wrst_n) begin
            state     <= IDLE;
            gnt       <= '0;
            sel       <= '0;
            last_sel  <= SEL_W'(NUM_REQ - 1);
            burst_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req && !bus.w_full) begin
                        state     <= BURST;
                        gnt       <= NUM_REQ'(1) << pick;
                        sel       <= pick;
                        last_sel  <= pick;
                        burst_cnt <= '0;
                    end
                end
                BURST: begin
                    if (w_en) begin
                        burst_cnt <= burst_cnt + CNT_W'(1);
                    end
                    if (!bus.req[sel] || (w_en && last_beat)) begin
                        state <= IDLE;
                        gnt   <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

    assign bus.gnt    = gnt;
    assign bus.busy   = busy;
    assign bus.w_en   = w_en;
    assign bus.ack    = w_en ? (NUM_REQ'(1) << sel) : '0;
    assign bus.w_data = busy ? bus.req_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH] : '0;

endmodule

// File: tb/tb_w_port_arbiter.sv
// Directed scenarios plus random traffic against a transaction-level arbiter model.
module tb_w_port_arbiter;
    import w_arb_pkg::*;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic w_clk  = 1'b0;
    logic wrst_n = 1'b0;

    w_port_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus();

    w_port_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .w_clk  (w_clk),
        .wrst_n (wrst_n),
        .bus    (bus)
    );

    always #5 w_clk = ~w_clk;

    int total = 0;
    int bad   = 0;

    // reference model: who owns the port, how many words written, who won last
    int m_owner = -1;
    int m_cnt   = 0;
    int m_last  = N - 1;

    logic [N-1:0] last_ack = '0;
    logic [N-1:0] prev_gnt = '0;
    int           dq[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic new_word(input int i);
        bus.req[i] = 1'b1;
        bus.req_data[i*DW +: DW] = DW'($urandom);
    endtask

    // One cycle: inputs already driven just after negedge; check, advance model.
    task automatic step();
        logic [N-1:0]  eg;
        logic [N-1:0]  ea;
        logic          ew;
        logic [DW-1:0] ed;
        #1;
        eg = '0;
        ew = 1'b0;
        ed = '0;
        if (m_owner >= 0) begin
            eg[m_owner] = 1'b1;
            ed = bus.req_data[m_owner*DW +: DW];
            ew = wrst_n && bus.req[m_owner] && !bus.w_full;
        end
        ea = ew ? eg : '0;
        check("gnt",    32'(bus.gnt),    32'(eg));
        check("w_en",   32'(bus.w_en),   32'(ew));
        check("ack",    32'(bus.ack),    32'(ea));
        check("w_data", 32'(bus.w_data), 32'(ed));
        check("busy",   32'(bus.busy),   32'(m_owner >= 0));
        if (bus.gnt != '0 && prev_gnt == '0) begin
            for (int k = 0; k < N; k++) if (bus.gnt[k]) dq.push_back(k);
        end
        prev_gnt = bus.gnt;
        last_ack = ea;
        if (!wrst_n) begin
            m_owner = -1;
            m_cnt   = 0;
            m_last  = N - 1;
        end else if (m_owner < 0) begin
            if (bus.req != '0 && !bus.w_full) begin
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (m_last + k) % N;
                    if (bus.req[c]) begin
                        m_owner = c;
                        break;
                    end
                end
                m_last = m_owner;
                m_cnt  = 0;
            end
        end else begin
            if (!bus.req[m_owner]) begin
                m_owner = -1;
            end else if (ew) begin
                m_cnt++;
                if (m_cnt == MB) m_owner = -1;
            end
        end
        @(negedge w_clk);
    endtask

    task automatic do_reset();
        wrst_n     = 1'b0;
        bus.req    = '0;
        bus.w_full = 1'b0;
        step();
        step();
        wrst_n = 1'b1;
        dq.delete();
    endtask

    // Re-arm acked requesters in mask with fresh data; others keep holding.
    task automatic refresh(input logic [N-1:0] mask);
        for (int i = 0; i < N; i++) begin
            if (last_ack[i]) begin
                if (mask[i]) new_word(i);
                else bus.req[i] = 1'b0;
            end
        end
    endtask

    initial begin
        int acks;
        int guard;
        bus.req      = '0;
        bus.req_data = '0;
        bus.w_full   = 1'b0;
        @(negedge w_clk);
        do_reset();
        check("rst_gnt",  32'(bus.gnt),    32'h0);
        check("rst_busy", 32'(bus.busy),   32'h0);
        check("rst_data", 32'(bus.w_data), 32'h0);

        // single requester: latency, full burst, idle gap, re-grant
        new_word(0);
        step();
        check("lat_gnt", 32'(bus.gnt), 32'h1);
        for (int c = 0; c < 12; c++) begin
            refresh(4'b0001);
            step();
        end
        check("regrant_cnt", 32'(dq.size()), 32'd3);
        check("regrant_who", 32'(dq[1]), 32'd0);

        // all requesting: grant order 0,1,2,3,0
        do_reset();
        for (int i = 0; i < N; i++) new_word(i);
        for (int c = 0; c < 27; c++) begin
            refresh(4'b1111);
            step();
        end
        check("rr_cnt", 32'(dq.size() >= 5), 32'd1);
        for (int k = 0; k < 5 && k < dq.size(); k++) check("rr_order", 32'(dq[k]), 32'(k % N));

        // full stalls mid-burst for three cycles
        do_reset();
        new_word(1);
        acks = 0;
        for (int c = 0; c < 14; c++) begin
            refresh(4'b0010);
            if (last_ack[1]) acks++;
            bus.w_full = (acks >= 2 && acks < 100 && c < 14) ? 1'b1 : 1'b0;
            if (acks == 2 && bus.w_full) begin
                for (int s = 0; s < 3; s++) begin
                    step();
                    check("stall_gnt", 32'(bus.gnt), 32'h2);
                end
                bus.w_full = 1'b0;
                acks = 100;
            end
            step();
        end

        // requester 2 drops after one ack; pending 3 granted next
        do_reset();
        new_word(2);
        new_word(3);
        for (int c = 0; c < 8; c++) begin
            refresh(4'b1000);
            step();
        end
        check("drop_cnt", 32'(dq.size() >= 2), 32'd1);
        if (dq.size() >= 2) begin
            check("drop_first", 32'(dq[0]), 32'd2);
            check("drop_next",  32'(dq[1]), 32'd3);
        end

        // reset mid-burst at burst_cnt=2
        do_reset();
        new_word(2);
        guard = 0;
        while (!(m_owner == 2 && m_cnt == 2) && guard < 20) begin
            refresh(4'b0100);
            step();
            guard++;
        end
        if (guard >= 20) begin
            total++;
            bad++;
            $display("FAIL rst_mid timeout waiting for burst_cnt=2");
        end
        refresh(4'b0100);
        wrst_n = 1'b0;
        step();
        check("rst_mid_gnt", 32'(bus.gnt), 32'h0);
        wrst_n = 1'b1;
        new_word(0);
        step();
        check("rst_mid_next", 32'(bus.gnt), 32'h1);

        // full held in idle blocks the grant
        do_reset();
        bus.w_full = 1'b1;
        new_word(3);
        for (int c = 0; c < 3; c++) begin
            step();
            check("full_idle", 32'(bus.gnt), 32'h0);
        end
        bus.w_full = 1'b0;
        step();
        check("full_release", 32'(bus.gnt), 32'h8);

        // random traffic, drops, stalls and occasional resets
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (last_ack[i]) begin
                    if ($urandom_range(0, 3) != 0) new_word(i);
                    else bus.req[i] = 1'b0;
                end else if (!bus.req[i]) begin
                    if ($urandom_range(0, 3) == 0) new_word(i);
                end else if ($urandom_range(0, 31) == 0) begin
                    bus.req[i] = 1'b0;
                end
            end
            bus.w_full = ($urandom_range(0, 4) == 0);
            wrst_n     = ($urandom_range(0, 99) != 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
